// File: rtl/pps_gen.sv
// Programmable PPS generator: one-second period counter, pulse, flag, seconds.
// Define PPS_GEN_SYNC_EN for one-shot phase alignment to sync_flag_i.
module pps_gen #(
  parameter int CLK_FREQ      = 125000000,
  parameter int WIDTH_SHIFT   = 16,
  parameter int DEFAULT_WIDTH = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [7:0]  width_i,
  input  logic        width_wr_i,
  input  logic        arm_i,
  input  logic        sync_flag_i,
  output logic        pps_o,
  output logic        pps_flag_o,
  output logic [31:0] seconds_o,
  output logic        locked_o
);

`ifdef PPS_GEN_SYNC_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ARMED = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;
`endif

  localparam logic [31:0] TOP = 32'(CLK_FREQ - 1);
  localparam logic [39:0] LIM = 40'(CLK_FREQ - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cnt_nxt;
  logic [7:0]  wreg_q, wreg_d;
  logic [7:0]  wact_q, wact_d;
  logic [39:0] w_full, w_lim;
  logic        start_d, pps_d, lock_d, run_d;

  assign cnt_nxt = (cnt_q == TOP) ? 32'd0 : cnt_q + 32'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lock_d  = locked_o;
    wreg_d  = width_wr_i ? width_i : wreg_q;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = 32'd0;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = 32'd0;
        end
        RUN: begin
          cnt_d = cnt_nxt;
`ifdef PPS_GEN_SYNC_EN
          if (arm_i) begin
            state_d = ARMED;
            lock_d  = 1'b0;
          end
`endif
        end
`ifdef PPS_GEN_SYNC_EN
        ARMED: begin
          if (sync_flag_i) begin
            state_d = RUN;
            cnt_d   = 32'd0;
            lock_d  = 1'b1;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end
      endcase
    end
    run_d   = (state_d != IDLE);
    start_d = run_d && (cnt_d == 32'd0);
    wact_d  = start_d ? wreg_d : wact_q;
    w_full  = {32'd0, wact_d} << WIDTH_SHIFT;
    // Clamp so the pin always sees at least one low cycle per period.
    w_lim   = (w_full > LIM) ? LIM : w_full;
    pps_d   = run_d && ({8'd0, cnt_d} < w_lim);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      wreg_q     <= 8'(DEFAULT_WIDTH);
      wact_q     <= 8'(DEFAULT_WIDTH);
      pps_o      <= 1'b0;
      pps_flag_o <= 1'b0;
      seconds_o  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wreg_q     <= wreg_d;
      wact_q     <= wact_d;
      pps_o      <= pps_d;
      pps_flag_o <= start_d;
      seconds_o  <= seconds_o + {31'd0, pps_flag_o};
    end
  end

`ifdef PPS_GEN_SYNC_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) locked_o <= 1'b0;
    else          locked_o <= lock_d;
  end
`else
  logic unused_sync;
  assign unused_sync = arm_i ^ sync_flag_i ^ lock_d;
  assign locked_o    = 1'b0;
`endif

endmodule
